// File: rtl/preg_release_queue_if.sv
// Bundle of commit-side and freelist-side signals for the preg release queue.
// Member names carry the direction as seen by the queue (i_ into it, o_ out of it).
interface preg_release_queue_if #(
  parameter int PREG_IDX_WIDTH = 6,
  parameter int LOG_DEPTH      = 3
);

  logic                      i_commit0_valid;
  logic [PREG_IDX_WIDTH-1:0] i_commit0_old_preg;
  logic                      i_commit1_valid;
  logic [PREG_IDX_WIDTH-1:0] i_commit1_old_preg;
  logic                      o_commit_ready;
  logic                      i_drain_en;
  logic                      o_free0_valid;
  logic [PREG_IDX_WIDTH-1:0] o_free0_data;
  logic                      o_free1_valid;
  logic [PREG_IDX_WIDTH-1:0] o_free1_data;
  logic [LOG_DEPTH:0]        o_count;
  logic                      o_overflow_err;

  // Commit stage and freelist side, driving the queue.
  modport master (
    output i_commit0_valid, i_commit0_old_preg,
    output i_commit1_valid, i_commit1_old_preg,
    output i_drain_en,
    input  o_commit_ready,
    input  o_free0_valid, o_free0_data,
    input  o_free1_valid, o_free1_data,
    input  o_count, o_overflow_err
  );

  // The release queue itself.
  modport slave (
    input  i_commit0_valid, i_commit0_old_preg,
    input  i_commit1_valid, i_commit1_old_preg,
    input  i_drain_en,
    output o_commit_ready,
    output o_free0_valid, o_free0_data,
    output o_free1_valid, o_free1_data,
    output o_count, o_overflow_err
  );

endinterface

// File: rtl/preg_release_queue.sv
// Preg release queue: collects up to two retiring old pregs per cycle into a
// circular FIFO and drains them in order onto the two freelist write ports.
// Preg 0 is never freed and is filtered out at the input.
module preg_release_queue #(
  parameter int DEPTH          = 8,
  parameter int LOG_DEPTH      = 3,
  parameter int PREG_IDX_WIDTH = 6
) (
  input logic                clock,
  input logic                reset_n,
  preg_release_queue_if.slave io_bus
);

  localparam logic [LOG_DEPTH:0] DEPTH_W = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] ONE_W   = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH:0] TWO_W   = (LOG_DEPTH + 1)'(2);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PREG_IDX_WIDTH-1:0] r_entries [DEPTH];
  logic [LOG_DEPTH:0]        r_head;
  logic [LOG_DEPTH:0]        r_tail;
  logic                      r_overflow;

  logic                      w_acc0;
  logic                      w_acc1;
  logic [LOG_DEPTH:0]        w_count;
  logic [LOG_DEPTH:0]        w_space;
  logic [LOG_DEPTH:0]        w_numAcc;
  logic [LOG_DEPTH:0]        w_numWrite;
  logic [LOG_DEPTH:0]        w_numDrain;
  logic                      w_overflowHit;
  logic                      w_wr0;
  logic                      w_wr1;
  logic [PREG_IDX_WIDTH-1:0] w_wrData0;
  logic [PREG_IDX_WIDTH-1:0] w_wrData1;
  logic [LOG_DEPTH-1:0]      w_tailIdx0;
  logic [LOG_DEPTH-1:0]      w_tailIdx1;
  logic [LOG_DEPTH-1:0]      w_headIdx0;
  logic [LOG_DEPTH-1:0]      w_headIdx1;
  logic                      w_free0;
  logic                      w_free1;

  // Occupancy falls out of the pointer difference; the wrap bit makes full read as DEPTH.
  assign w_count    = r_tail - r_head;
  assign w_space    = DEPTH_W - w_count;
  assign w_tailIdx0 = r_tail[LOG_DEPTH-1:0];
  assign w_tailIdx1 = w_tailIdx0 + LOG_DEPTH'(1);
  assign w_headIdx0 = r_head[LOG_DEPTH-1:0];
  assign w_headIdx1 = w_headIdx0 + LOG_DEPTH'(1);

  // Filter preg 0, compact accepted slots, and clip to the free space left.
  always_comb begin
    w_acc0        = io_bus.i_commit0_valid && (io_bus.i_commit0_old_preg != '0);
    w_acc1        = io_bus.i_commit1_valid && (io_bus.i_commit1_old_preg != '0);
    w_numAcc      = (LOG_DEPTH + 1)'(w_acc0) + (LOG_DEPTH + 1)'(w_acc1);
    w_overflowHit = 1'b0;
    w_numWrite    = w_numAcc;
    if (w_numAcc > w_space) begin
      w_overflowHit = 1'b1;
      w_numWrite    = w_space;
    end
    w_wr0     = (w_numWrite >= ONE_W);
    w_wr1     = (w_numWrite >= TWO_W);
    w_wrData0 = w_acc0 ? io_bus.i_commit0_old_preg : io_bus.i_commit1_old_preg;
    w_wrData1 = io_bus.i_commit1_old_preg;
  end

  // Drain up to two entries from the head whenever the freelist allows it.
  always_comb begin
    w_free0    = io_bus.i_drain_en && (w_count >= ONE_W);
    w_free1    = io_bus.i_drain_en && (w_count >= TWO_W);
    w_numDrain = (LOG_DEPTH + 1)'(w_free0) + (LOG_DEPTH + 1)'(w_free1);
  end

  assign io_bus.o_free0_valid  = w_free0;
  assign io_bus.o_free0_data   = w_free0 ? r_entries[w_headIdx0] : '0;
  assign io_bus.o_free1_valid  = w_free1;
  assign io_bus.o_free1_data   = w_free1 ? r_entries[w_headIdx1] : '0;
  assign io_bus.o_commit_ready = (w_space >= TWO_W);
  assign io_bus.o_count        = w_count;
  assign io_bus.o_overflow_err = r_overflow;

  // Advance pointers by the number written and drained; latch any overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_head <= r_head + w_numDrain;
      r_tail <= r_tail + w_numWrite;
      if (w_overflowHit) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Store accepted pregs at the tail; writes only land in free slots, so they never alias a drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_wr0) begin
        r_entries[w_tailIdx0] <= w_wrData0;
      end
      if (w_wr1) begin
        r_entries[w_tailIdx1] <= w_wrData1;
      end
    end
  end

endmodule

// File: tb/tb_preg_release_queue.sv
// Testbench for preg_release_queue: drives directed and random commit/drain
// traffic, models the queue as an ordered list of pregs, and checks every
// free-port output against that list from a separate monitor.
module tb_preg_release_queue;

  localparam int DEPTH     = 8;
  localparam int LOG_DEPTH = 3;
  localparam int PW        = 6;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  preg_release_queue_if #(.PREG_IDX_WIDTH(PW), .LOG_DEPTH(LOG_DEPTH)) bus ();

  preg_release_queue #(
    .DEPTH(DEPTH),
    .LOG_DEPTH(LOG_DEPTH),
    .PREG_IDX_WIDTH(PW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .io_bus(bus)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: pregs held in the queue, in the order they will be freed.
  int expQ[$];
  int modelCount    = 0;
  bit modelOverflow = 1'b0;

  task automatic checkVal(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== 32'(expected)) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare one free port against the head of the expected list.
  task automatic checkPort(input string name, input logic valid, input logic [PW-1:0] data);
    int expData;
    if (valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: got valid preg 0x%0h, expected nothing pending at %0t", name, data, $time);
      end else begin
        expData = expQ.pop_front();
        checkVal({name, "_data"}, 32'(data), expData);
      end
    end else begin
      checkVal({name, "_idle_data"}, 32'(data), 0);
    end
  endtask

  task automatic checkOutput();
    int expV0;
    int expV1;
    expV0 = (bus.i_drain_en === 1'b1 && modelCount >= 1) ? 1 : 0;
    expV1 = (bus.i_drain_en === 1'b1 && modelCount >= 2) ? 1 : 0;
    checkVal("count", 32'(bus.o_count), modelCount);
    checkVal("commit_ready", 32'(bus.o_commit_ready), ((DEPTH - modelCount) >= 2) ? 1 : 0);
    checkVal("overflow_err", 32'(bus.o_overflow_err), int'(modelOverflow));
    checkVal("free0_valid", 32'(bus.o_free0_valid), expV0);
    checkVal("free1_valid", 32'(bus.o_free1_valid), expV1);
    checkPort("free0", bus.o_free0_valid, bus.o_free0_data);
    checkPort("free1", bus.o_free1_valid, bus.o_free1_data);
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clock) checkOutput();

  // One cycle of traffic, called at posedge+1; updates the model at the edge.
  task automatic applyStimulus(input bit v0, input int p0, input bit v1, input int p1, input bit de);
    int acc[$];
    int space;
    int drained;
    int written;
    bus.i_commit0_valid    = v0;
    bus.i_commit0_old_preg = PW'(p0);
    bus.i_commit1_valid    = v1;
    bus.i_commit1_old_preg = PW'(p1);
    bus.i_drain_en         = de;
    @(posedge clock);
    if (v0 && p0 != 0) acc.push_back(p0);
    if (v1 && p1 != 0) acc.push_back(p1);
    space   = DEPTH - modelCount;
    drained = de ? ((modelCount >= 2) ? 2 : modelCount) : 0;
    if (acc.size() > space) modelOverflow = 1'b1;
    written = 0;
    foreach (acc[i]) begin
      if (i < space) begin
        expQ.push_back(acc[i]);
        written++;
      end
    end
    modelCount = modelCount + written - drained;
    #1;
  endtask

  // Bound the run so a stuck simulation still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0;
    int v1;
    int p0;
    int p1;
    int de;
    bus.i_commit0_valid    = 1'b0;
    bus.i_commit0_old_preg = '0;
    bus.i_commit1_valid    = 1'b0;
    bus.i_commit1_old_preg = '0;
    bus.i_drain_en         = 1'b0;
    reset_n                = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Pair commit, drained the following cycle.
    applyStimulus(1, 'h05, 1, 'h09, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Preg 0 in slot 0 is dropped; slot 1 lands at the tail.
    applyStimulus(1, 'h00, 1, 'h12, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Fill with draining held off, then push past capacity.
    for (int k = 0; k < 4; k++) applyStimulus(1, 'h30 + 2 * k, 1, 'h31 + 2 * k, 0);
    applyStimulus(1, 'h21, 1, 'h22, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (5) applyStimulus(0, 0, 0, 0, 1);

    // Stream 1..20 through the pointer wrap.
    for (int k = 0; k < 10; k++) applyStimulus(1, 2 * k + 1, 1, 2 * k + 2, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);

    // Single-slot fills reach odd occupancies such as 7.
    for (int k = 0; k < 7; k++) applyStimulus(k[0], 'h10 + k, ~k[0], 'h18 + k, 0);
    repeat (5) applyStimulus(0, 0, 0, 0, 1);

    // Random traffic, honouring the ready rule from the model's occupancy.
    for (int n = 0; n < 400; n++) begin
      v0 = int'($urandom_range(0, 1));
      v1 = int'($urandom_range(0, 1));
      p0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      p1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      de = ($urandom_range(0, 9) < 6) ? 1 : 0;
      if ((DEPTH - modelCount) < 2) begin
        v0 = 0;
        v1 = 0;
      end
      applyStimulus(v0[0], p0, v1[0], p1, de[0]);
    end
    repeat (6) applyStimulus(0, 0, 0, 0, 1);

    // Fill to 5, then assert reset between edges.
    applyStimulus(1, 'h01, 1, 'h02, 0);
    applyStimulus(1, 'h03, 1, 'h04, 0);
    applyStimulus(1, 'h05, 0, 0, 0);
    bus.i_commit0_valid = 1'b0;
    bus.i_commit1_valid = 1'b0;
    bus.i_drain_en      = 1'b1;
    #2;
    reset_n = 1'b0;
    expQ.delete();
    modelCount    = 0;
    modelOverflow = 1'b0;
    #1;
    checkVal("reset_count", 32'(bus.o_count), 0);
    checkVal("reset_free0_valid", 32'(bus.o_free0_valid), 0);
    checkVal("reset_free1_valid", 32'(bus.o_free1_valid), 0);
    checkVal("reset_overflow_err", 32'(bus.o_overflow_err), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    applyStimulus(1, 'h33, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);

    checkVal("pending_at_end", 32'(expQ.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
